// File: rtl/aes_pkg.sv
// Shared AES constants, FSM state type and affine transforms for the iterative S-box.
package aes_pkg;

  localparam logic [7:0]  GF_POLY   = 8'h1B;
  localparam logic [7:0]  AFF_C     = 8'h63;
  localparam logic [7:0]  INV_AFF_D = 8'h05;
  localparam int unsigned EXP_STEPS = 13;

  typedef enum logic [0:0] {IDLE, EXP} state_e;

  // Rotate-left form: bit i of rotl(a, n) is a[(i - n) % 8].
  function automatic logic [7:0] fwd_affine(logic [7:0] a);
    return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]} ^ {a[3:0], a[7:4]} ^ AFF_C;
  endfunction

  function automatic logic [7:0] inv_affine(logic [7:0] a);
    return {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ INV_AFF_D;
  endfunction

endpackage

// File: rtl/sbox_iter_00_if.sv
// Byte-wide S-box request/response bundle between SubBytes controller and responder.
interface sbox_iter_00_if;

  logic       start_i;
  logic       decrypt_i;
  logic [7:0] data_i;
  logic       ready_o;
  logic       busy_o;
  logic [7:0] data_o;

  modport master (
    output start_i,
    output decrypt_i,
    output data_i,
    input  ready_o,
    input  busy_o,
    input  data_o
  );

  modport slave (
    input  start_i,
    input  decrypt_i,
    input  data_i,
    output ready_o,
    output busy_o,
    output data_o
  );

endinterface

// File: rtl/gf256_mul.sv
// Combinational GF(2^8) multiplier, polynomial 0x11B, shift-and-add with conditional reduction.
module gf256_mul
  import aes_pkg::*;
(
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [7:0] p_o
);

  always_comb begin
    logic [7:0] aa;
    logic [7:0] bb;
    logic [7:0] p;
    aa = a_i;
    bb = b_i;
    p  = 8'h00;
    for (int unsigned i = 0; i < 8; i++) begin
      if (bb[0]) begin
        p = p ^ aa;
      end
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? GF_POLY : 8'h00);
      bb = {1'b0, bb[7:1]};
    end
    p_o = p;
  end

endmodule

// File: rtl/sbox_iter_00.sv
// Iterative AES S-box responder: x^254 via square-and-multiply on one shared GF multiplier.
module sbox_iter_00
  import aes_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  sbox_iter_00_if.slave  bus
);

  localparam logic [3:0] LAST_STEP = 4'(EXP_STEPS - 1);

  state_e     state_q, state_d;
  logic [3:0] step_q, step_d;
  logic [7:0] base_q, base_d;
  logic [7:0] acc_q, acc_d;
  logic       dir_q, dir_d;
  logic [7:0] data_q, data_d;
  logic       ready_q, ready_d;

  logic [7:0] mul_b;
  logic [7:0] mul_p;
  logic [7:0] start_val;

  // Even steps square the accumulator, odd steps multiply in the base.
  assign mul_b = step_q[0] ? base_q : acc_q;

  gf256_mul u_mul (
    .a_i (acc_q),
    .b_i (mul_b),
    .p_o (mul_p)
  );

  assign start_val = bus.decrypt_i ? inv_affine(bus.data_i) : bus.data_i;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    base_d  = base_q;
    acc_d   = acc_q;
    dir_d   = dir_q;
    data_d  = data_q;
    ready_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          base_d  = start_val;
          acc_d   = start_val;
          dir_d   = bus.decrypt_i;
          step_d  = 4'd0;
          state_d = EXP;
        end
      end
      EXP: begin
        acc_d  = mul_p;
        step_d = step_q + 4'd1;
        if (step_q == LAST_STEP) begin
          data_d  = dir_q ? mul_p : fwd_affine(mul_p);
          ready_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      step_q  <= 4'd0;
      base_q  <= 8'h00;
      acc_q   <= 8'h00;
      dir_q   <= 1'b0;
      data_q  <= 8'h00;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      base_q  <= base_d;
      acc_q   <= acc_d;
      dir_q   <= dir_d;
      data_q  <= data_d;
      ready_q <= ready_d;
    end
  end

  assign bus.ready_o = ready_q;
  assign bus.busy_o  = (state_q == EXP);
  assign bus.data_o  = data_q;

endmodule

// File: tb/tb_sbox_iter_00.sv
// Self-checking bench for sbox_iter_00: vector table, exhaustive round trip, corner sequences.
module tb_sbox_iter_00;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  sbox_iter_00_if bus ();

  sbox_iter_00 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] data;
    int         acc_cyc;
  } exp_t;

  typedef struct {
    logic       dec;
    logic [7:0] din;
    logic [7:0] dout;
  } vec_t;

  exp_t       sb[$];
  vec_t       vecs[6];
  logic [7:0] m_sbox[256];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;

  function automatic logic [7:0] m_mul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1B;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] m_inv(logic [7:0] x);
    if (x == 8'h00) return 8'h00;
    for (int y = 1; y < 256; y++) begin
      if (m_mul(x, 8'(y)) == 8'h01) return 8'(y);
    end
    return 8'h00;
  endfunction

  function automatic logic [7:0] m_aff(logic [7:0] a);
    logic [7:0] b;
    logic [7:0] c;
    logic [2:0] k;
    c = 8'h63;
    for (int i = 0; i < 8; i++) begin
      k = 3'(i);
      b[k] = a[k] ^ a[k + 3'd4] ^ a[k + 3'd5] ^ a[k + 3'd6] ^ a[k + 3'd7] ^ c[k];
    end
    return b;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic on_ready();
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_ready: got ready_o=1 data_o=%0h, required no pulse (cycle %0d)",
               bus.data_o, cyc);
    end else begin
      e = sb.pop_front();
      check("result", 32'(bus.data_o), 32'(e.data));
      check("latency", 32'(cyc - e.acc_cyc), 32'd13);
      check("busy_at_ready", 32'(bus.busy_o), 32'd0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (bus.ready_o === 1'b1) on_ready();
  endtask

  task automatic start_op(logic dec, logic [7:0] din, logic [7:0] expv);
    bus.start_i   = 1'b1;
    bus.decrypt_i = dec;
    bus.data_i    = din;
    sb.push_back('{data: expv, acc_cyc: cyc + 1});
    tick();
    bus.start_i = 1'b0;
    check("busy_after_accept", 32'(bus.busy_o), 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL timeout: got %0d results pending, required 0 (cycle %0d)", sb.size(), cyc);
      sb.delete();
    end
  endtask

  initial begin
    vecs[0] = '{dec: 1'b0, din: 8'h00, dout: 8'h63};
    vecs[1] = '{dec: 1'b0, din: 8'h01, dout: 8'h7C};
    vecs[2] = '{dec: 1'b0, din: 8'h53, dout: 8'hED};
    vecs[3] = '{dec: 1'b1, din: 8'h63, dout: 8'h00};
    vecs[4] = '{dec: 1'b1, din: 8'h7C, dout: 8'h01};
    vecs[5] = '{dec: 1'b1, din: 8'hED, dout: 8'h53};
    for (int x = 0; x < 256; x++) m_sbox[x] = m_aff(m_inv(8'(x)));

    // Reset state with start_i high
    reset         = 1'b0;
    bus.start_i   = 1'b1;
    bus.decrypt_i = 1'b0;
    bus.data_i    = 8'h53;
    repeat (3) begin
      tick();
      check("rst_ready", 32'(bus.ready_o), 32'd0);
      check("rst_busy", 32'(bus.busy_o), 32'd0);
      check("rst_data", 32'(bus.data_o), 32'd0);
    end
    bus.start_i = 1'b0;
    reset       = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) begin
      start_op(vecs[i].dec, vecs[i].din, vecs[i].dout);
      drain();
    end

    for (int x = 0; x < 256; x++) begin
      start_op(1'b0, 8'(x), m_sbox[x]);
      drain();
      start_op(1'b1, m_sbox[x], 8'(x));
      drain();
    end

    // Back-to-back: start_i held high, second byte accepted on the cycle after ready_o
    begin
      int a;
      bus.start_i   = 1'b1;
      bus.decrypt_i = 1'b0;
      bus.data_i    = 8'h53;
      sb.push_back('{data: 8'hED, acc_cyc: cyc + 1});
      tick();
      a = cyc;
      bus.data_i = 8'h01;
      sb.push_back('{data: 8'h7C, acc_cyc: a + 14});
      repeat (14) tick();
      bus.start_i = 1'b0;
      drain();
    end

    // Start while busy must be ignored
    start_op(1'b0, 8'h53, 8'hED);
    repeat (4) tick();
    bus.start_i   = 1'b1;
    bus.decrypt_i = 1'b1;
    bus.data_i    = 8'h00;
    tick();
    bus.start_i = 1'b0;
    drain();
    repeat (20) tick();
    check("idle_busy", 32'(bus.busy_o), 32'd0);
    check("held_data", 32'(bus.data_o), 32'hED);

    // Mid-operation reset
    start_op(1'b0, 8'h53, 8'hED);
    repeat (6) tick();
    reset = 1'b0;
    #1;
    sb.delete();
    check("midrst_data", 32'(bus.data_o), 32'd0);
    check("midrst_busy", 32'(bus.busy_o), 32'd0);
    check("midrst_ready", 32'(bus.ready_o), 32'd0);
    bus.start_i = 1'b1;
    repeat (2) begin
      tick();
      check("midrst_hold_busy", 32'(bus.busy_o), 32'd0);
      check("midrst_hold_data", 32'(bus.data_o), 32'd0);
    end
    bus.start_i = 1'b0;
    reset       = 1'b1;
    tick();
    start_op(1'b0, 8'h01, 8'h7C);
    drain();
    repeat (16) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
